// File: rtl/vga_menu_pkg.sv
// Shared types and default geometry for the main-menu renderer.
// Defaults describe the 640x480 five-entry menu screen.
package vga_menu_pkg;

    typedef enum logic [1:0] {MENU, CONFIRM, HOLD} menu_state_t;

    // Ordered so that a larger code means a higher-priority request.
    typedef enum logic [2:0] {
        REQ_NONE, REQ_RIGHT, REQ_LEFT, REQ_DOWN, REQ_UP
    } req_t;

    localparam int DEF_H_RES        = 640;
    localparam int DEF_V_RES        = 480;
    localparam int DEF_NUM_OPTIONS  = 5;
    localparam int DEF_NUM_ROWS     = 3;
    localparam int DEF_COL0_X       = 130;
    localparam int DEF_ROW0_Y       = 224;
    localparam int DEF_COL_PITCH    = 227;
    localparam int DEF_ROW_PITCH    = 58;
    localparam int DEF_BOX_W        = 153;
    localparam int DEF_BOX_H        = 31;
    localparam int DEF_BOX_T        = 3;
    localparam int DEF_BORDER_T     = 3;
    localparam int DEF_LOGO_X       = 204;
    localparam int DEF_LOGO_Y       = 40;
    localparam int DEF_LOGO_W       = 231;
    localparam int DEF_LOGO_H       = 156;
    localparam int DEF_LOGO_BASE    = 25940;
    localparam int DEF_BLINK_FRAMES = 16;

    localparam logic [18:0] DEF_BLANK_ADDR  = 19'd1923;
    localparam logic [7:0]  DEF_OVERLAY_IDX = 8'd7;

endpackage

// File: rtl/vga_menu_renderer_ctrl.sv
// Menu selection controller: pending request latch, wrap navigation,
// blink counter and confirm FSM.
module menu_select_ctrl
    import vga_menu_pkg::*;
#(
    parameter int NUM_OPTIONS  = DEF_NUM_OPTIONS,
    parameter int NUM_ROWS     = DEF_NUM_ROWS,
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       frameStart,
    input  logic       menuActive,
    input  logic       btnUp,
    input  logic       btnDown,
    input  logic       btnLeft,
    input  logic       btnRight,
    input  logic       btnSelect,
    output logic [2:0] selIdx,
    output logic       cursorOn,
    output logic [2:0] choice,
    output logic       choiceValid
);

    menu_state_t r_state;
    req_t        r_pend;
    req_t        w_new;
    req_t        w_req;
    logic [2:0]  r_sel;
    logic [2:0]  w_next;
    logic [15:0] r_cnt;
    logic        r_cur;
    logic [2:0]  r_choice;
    logic        r_valid;
    logic        w_nav;

    always_comb begin
        w_nav = menuActive && (r_state == MENU) && !btnSelect;
        w_new = REQ_NONE;
        if (w_nav) begin
            priority case (1'b1)
                btnUp:    w_new = REQ_UP;
                btnDown:  w_new = REQ_DOWN;
                btnLeft:  w_new = REQ_LEFT;
                btnRight: w_new = REQ_RIGHT;
                default:  w_new = REQ_NONE;
            endcase
        end
        // A higher-priority pulse replaces the pending one; otherwise keep it.
        w_req = (w_new > r_pend) ? w_new : r_pend;
        w_next = r_sel;
        case (w_req)
            REQ_UP:
                w_next = (r_sel == 3'd0) ? 3'(NUM_OPTIONS - 1)
                                         : r_sel - 3'd1;
            REQ_DOWN:
                w_next = (int'(r_sel) == NUM_OPTIONS - 1) ? 3'd0
                                                          : r_sel + 3'd1;
            REQ_RIGHT:
                if (int'(r_sel) + NUM_ROWS < NUM_OPTIONS)
                    w_next = 3'(int'(r_sel) + NUM_ROWS);
            REQ_LEFT:
                if (int'(r_sel) >= NUM_ROWS)
                    w_next = 3'(int'(r_sel) - NUM_ROWS);
            default: w_next = r_sel;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state  <= MENU;
            r_pend   <= REQ_NONE;
            r_sel    <= 3'd0;
            r_cnt    <= 16'd0;
            r_cur    <= 1'b1;
            r_choice <= 3'd0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                MENU: begin
                    if (menuActive && btnSelect) begin
                        r_state <= CONFIRM;
                        r_pend  <= REQ_NONE;
                    end else if (frameStart) begin
                        r_pend <= REQ_NONE;
                        if (w_req != REQ_NONE) begin
                            r_sel <= w_next;
                            r_cnt <= 16'd0;
                            r_cur <= 1'b1;
                        end else if (BLINK_FRAMES == 0) begin
                            r_cur <= 1'b1;
                        end else if (r_cnt == 16'(BLINK_FRAMES - 1)) begin
                            r_cnt <= 16'd0;
                            r_cur <= ~r_cur;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end else begin
                        r_pend <= w_req;
                    end
                end
                CONFIRM: begin
                    r_choice <= r_sel;
                    r_valid  <= 1'b1;
                    r_cnt    <= 16'd0;
                    r_cur    <= 1'b1;
                    r_state  <= HOLD;
                end
                HOLD: begin
                    if (!menuActive) begin
                        r_sel   <= 3'd0;
                        r_pend  <= REQ_NONE;
                        r_state <= MENU;
                    end
                end
                default: r_state <= MENU;
            endcase
        end
    end

    assign selIdx      = r_sel;
    assign cursorOn    = r_cur;
    assign choice      = r_choice;
    assign choiceValid = r_valid;

endmodule

// File: rtl/vga_menu_renderer.sv
// Main-menu pixel processor: scan address to ROM address, border and
// selection-box overlay, two-stage aligned with the ROM/palette read.
module vga_menu_renderer
    import vga_menu_pkg::*;
#(
    parameter int          H_RES        = DEF_H_RES,
    parameter int          V_RES        = DEF_V_RES,
    parameter int          NUM_OPTIONS  = DEF_NUM_OPTIONS,
    parameter int          NUM_ROWS     = DEF_NUM_ROWS,
    parameter int          COL0_X       = DEF_COL0_X,
    parameter int          ROW0_Y       = DEF_ROW0_Y,
    parameter int          COL_PITCH    = DEF_COL_PITCH,
    parameter int          ROW_PITCH    = DEF_ROW_PITCH,
    parameter int          BOX_W        = DEF_BOX_W,
    parameter int          BOX_H        = DEF_BOX_H,
    parameter int          BOX_T        = DEF_BOX_T,
    parameter int          BORDER_T     = DEF_BORDER_T,
    parameter int          LOGO_X       = DEF_LOGO_X,
    parameter int          LOGO_Y       = DEF_LOGO_Y,
    parameter int          LOGO_W       = DEF_LOGO_W,
    parameter int          LOGO_H       = DEF_LOGO_H,
    parameter int          LOGO_BASE    = DEF_LOGO_BASE,
    parameter logic [18:0] BLANK_ADDR   = DEF_BLANK_ADDR,
    parameter logic [7:0]  OVERLAY_IDX  = DEF_OVERLAY_IDX,
    parameter int          BLINK_FRAMES = DEF_BLINK_FRAMES
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [18:0] curAddress,
    input  logic        frameStart,
    input  logic        menuActive,
    input  logic        btnUp,
    input  logic        btnDown,
    input  logic        btnLeft,
    input  logic        btnRight,
    input  logic        btnSelect,
    input  logic [7:0]  indexIn,
    input  logic [23:0] colorIn,
    output logic [18:0] addrToRead,
    output logic [7:0]  indexOut,
    output logic [23:0] colorOut,
    output logic [2:0]  selIdx,
    output logic        choiceValid,
    output logic [2:0]  choice
);

    logic [2:0]  w_sel;
    logic        w_cursor;
    logic [9:0]  w_x;
    logic [9:0]  w_y;
    int          w_xi;
    int          w_yi;
    int          w_sx;
    int          w_sy;
    logic        w_logo;
    logic        w_border;
    logic        w_inbox;
    logic        w_edge;
    logic        w_flag;
    logic [18:0] w_addr;
    logic [18:0] r_addr;
    logic        r_flag;
    logic [7:0]  r_idx;
    logic [23:0] r_color;

    menu_select_ctrl #(
        .NUM_OPTIONS  (NUM_OPTIONS),
        .NUM_ROWS     (NUM_ROWS),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_ctrl (
        .clock       (clock),
        .resetn      (resetn),
        .frameStart  (frameStart),
        .menuActive  (menuActive),
        .btnUp       (btnUp),
        .btnDown     (btnDown),
        .btnLeft     (btnLeft),
        .btnRight    (btnRight),
        .btnSelect   (btnSelect),
        .selIdx      (w_sel),
        .cursorOn    (w_cursor),
        .choice      (choice),
        .choiceValid (choiceValid)
    );

    assign w_x = 10'(curAddress % 19'(H_RES));
    assign w_y = 10'(curAddress / 19'(H_RES));

    always_comb begin
        w_xi = int'(w_x);
        w_yi = int'(w_y);
        // Entries fill column-major.
        w_sx = COL0_X + (int'(w_sel) / NUM_ROWS) * COL_PITCH;
        w_sy = ROW0_Y + (int'(w_sel) % NUM_ROWS) * ROW_PITCH;
        w_logo = (w_xi >= LOGO_X) && (w_xi < LOGO_X + LOGO_W) &&
                 (w_yi >= LOGO_Y) && (w_yi < LOGO_Y + LOGO_H);
        w_border = (w_xi < BORDER_T) || (w_xi >= H_RES - BORDER_T) ||
                   (w_yi < BORDER_T) || (w_yi >= V_RES - BORDER_T);
        w_inbox = (w_xi >= w_sx) && (w_xi < w_sx + BOX_W) &&
                  (w_yi >= w_sy) && (w_yi < w_sy + BOX_H);
        w_edge = (w_xi < w_sx + BOX_T) || (w_xi >= w_sx + BOX_W - BOX_T) ||
                 (w_yi < w_sy + BOX_T) || (w_yi >= w_sy + BOX_H - BOX_T);
        w_flag = w_border || (w_inbox && w_edge && w_cursor);
        w_addr = w_logo
               ? 19'(LOGO_BASE + (w_xi - LOGO_X) + (w_yi - LOGO_Y) * H_RES)
               : BLANK_ADDR;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_addr  <= BLANK_ADDR;
            r_flag  <= 1'b0;
            r_idx   <= 8'd0;
            r_color <= 24'd0;
        end else begin
            r_addr  <= w_addr;
            r_flag  <= w_flag;
            r_idx   <= r_flag ? OVERLAY_IDX : indexIn;
            r_color <= colorIn;
        end
    end

    assign addrToRead = r_addr;
    assign indexOut   = r_idx;
    assign colorOut   = r_color;
    assign selIdx     = w_sel;

endmodule

// File: tb/tb_vga_menu_renderer.sv
// Directed bench for vga_menu_renderer: pixel pipeline, navigation,
// confirm handshake, blink and asynchronous reset.
module tb_vga_menu_renderer;

    localparam int UP = 0;
    localparam int DN = 1;
    localparam int LT = 2;
    localparam int RT = 3;
    localparam int SL = 4;

    logic        clock;
    logic        resetn;
    logic [18:0] curAddress;
    logic        frameStart;
    logic        fs2;
    logic        menuActive;
    logic        btnUp, btnDown, btnLeft, btnRight, btnSelect;
    logic        zero;
    logic [7:0]  indexIn;
    logic [23:0] colorIn;
    logic [18:0] addrToRead, a2;
    logic [7:0]  indexOut, i2;
    logic [23:0] colorOut, c2;
    logic [2:0]  selIdx, s2;
    logic        choiceValid, cv2;
    logic [2:0]  choice, ch2;

    int n_cmp = 0;
    int n_err = 0;

    vga_menu_renderer dut (
        .clock(clock), .resetn(resetn), .curAddress(curAddress),
        .frameStart(frameStart), .menuActive(menuActive),
        .btnUp(btnUp), .btnDown(btnDown), .btnLeft(btnLeft),
        .btnRight(btnRight), .btnSelect(btnSelect),
        .indexIn(indexIn), .colorIn(colorIn),
        .addrToRead(addrToRead), .indexOut(indexOut),
        .colorOut(colorOut), .selIdx(selIdx),
        .choiceValid(choiceValid), .choice(choice)
    );

    vga_menu_renderer #(.BLINK_FRAMES(2)) dut2 (
        .clock(clock), .resetn(resetn), .curAddress(curAddress),
        .frameStart(fs2), .menuActive(menuActive),
        .btnUp(zero), .btnDown(zero), .btnLeft(zero),
        .btnRight(zero), .btnSelect(zero),
        .indexIn(indexIn), .colorIn(colorIn),
        .addrToRead(a2), .indexOut(i2),
        .colorOut(c2), .selIdx(s2),
        .choiceValid(cv2), .choice(ch2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pix(input string tag, input int x, input int y,
                       input int ea, input int ei);
        curAddress = 19'(y * 640 + x);
        @(posedge clock); #1;
        chk({tag, "/addr"}, 32'(addrToRead), ea);
        @(posedge clock); #1;
        chk({tag, "/idx"}, 32'(indexOut), ei);
    endtask

    task automatic pix2(input string tag, input int x, input int y,
                        input int ei);
        curAddress = 19'(y * 640 + x);
        repeat (2) @(posedge clock);
        #1;
        chk(tag, 32'(i2), ei);
    endtask

    task automatic nav(input int b);
        case (b)
            UP:      btnUp = 1'b1;
            DN:      btnDown = 1'b1;
            LT:      btnLeft = 1'b1;
            RT:      btnRight = 1'b1;
            default: btnSelect = 1'b1;
        endcase
        @(posedge clock); #1;
        {btnUp, btnDown, btnLeft, btnRight, btnSelect} = '0;
    endtask

    task automatic fs();
        frameStart = 1'b1;
        @(posedge clock); #1;
        frameStart = 1'b0;
    endtask

    task automatic frame2();
        fs2 = 1'b1;
        @(posedge clock); #1;
        fs2 = 1'b0;
    endtask

    task automatic mv(input int b, input int es, input string tag);
        nav(b);
        fs();
        chk(tag, 32'(selIdx), es);
    endtask

    initial begin
        resetn = 1'b0;
        curAddress = '0;
        frameStart = 1'b0;
        fs2 = 1'b0;
        menuActive = 1'b1;
        {btnUp, btnDown, btnLeft, btnRight, btnSelect} = '0;
        zero = 1'b0;
        indexIn = 8'd3;
        colorIn = 24'hABCDEF;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_addr", 32'(addrToRead), 1923);
        chk("rst_idx", 32'(indexOut), 0);
        chk("rst_col", 32'(colorOut), 0);
        chk("rst_sel", 32'(selIdx), 0);
        chk("rst_ch", 32'(choice), 0);
        chk("rst_cv", 32'(choiceValid), 0);
        resetn = 1'b1;
        @(posedge clock); #1;

        // Latency: switch from a plain pixel to a border pixel.
        curAddress = 19'(100 * 640 + 320);
        repeat (3) @(posedge clock);
        #1;
        chk("lat_addr", 32'(addrToRead), 64456);
        curAddress = 19'(0);
        @(posedge clock); #1;
        chk("lat_1clk", 32'(indexOut), 3);
        @(posedge clock); #1;
        chk("lat_2clk", 32'(indexOut), 7);
        chk("color", 32'(colorOut), 32'h00ABCDEF);

        pix("b_tl", 0, 0, 1923, 7);
        pix("b_br", 639, 479, 1923, 7);
        pix("in33", 3, 3, 1923, 3);
        pix("x636", 636, 200, 1923, 3);
        pix("x637", 637, 200, 1923, 7);
        pix("y476", 320, 476, 1923, 3);
        pix("y477", 320, 477, 1923, 7);
        pix("logo0", 204, 40, 25940, 3);
        pix("logoN", 434, 195, 125370, 3);
        pix("logoR", 435, 195, 1923, 3);
        pix("logoL", 203, 100, 1923, 3);
        pix("bx0", 130, 224, 1923, 7);
        pix("bx_l", 132, 230, 1923, 7);
        pix("bx_in", 133, 230, 1923, 3);
        pix("bx_r", 282, 240, 1923, 7);
        pix("bx_out", 283, 240, 1923, 3);
        pix("bx_bot", 200, 254, 1923, 7);
        pix("bx_below", 200, 255, 1923, 3);
        pix("bx_bt", 200, 252, 1923, 7);
        pix("bx_mid", 200, 250, 1923, 3);
        pix("bx4_off", 357, 282, 1923, 3);

        nav(UP);
        chk("up_pending", 32'(selIdx), 0);
        fs();
        chk("up_wrap", 32'(selIdx), 4);
        pix("bx4_tl", 357, 282, 1923, 7);
        pix("bx4_br", 509, 312, 1923, 7);
        pix("bx0_off", 130, 224, 1923, 3);
        mv(DN, 0, "dn_wrap");

        mv(DN, 1, "dn1");
        mv(RT, 4, "rt1");
        mv(RT, 4, "rt_edge");
        mv(LT, 1, "lt4");
        mv(DN, 2, "dn2");
        mv(RT, 2, "rt_none");

        nav(DN);
        pix("mid_old", 130, 340, 1923, 7);
        pix("mid_new", 357, 224, 1923, 3);
        fs();
        chk("mid_sel", 32'(selIdx), 3);
        pix("aft_new", 357, 224, 1923, 7);
        pix("aft_old", 130, 340, 1923, 3);
        nav(DN);
        nav(UP);
        fs();
        chk("two_nav", 32'(selIdx), 2);

        btnDown = 1'b1;
        btnSelect = 1'b1;
        @(posedge clock); #1;
        {btnDown, btnSelect} = '0;
        chk("cv_early", 32'(choiceValid), 0);
        @(posedge clock); #1;
        chk("cv_pulse", 32'(choiceValid), 1);
        chk("choice", 32'(choice), 2);
        @(posedge clock); #1;
        chk("cv_end", 32'(choiceValid), 0);
        chk("sel_kept", 32'(selIdx), 2);
        mv(UP, 2, "hold_nav");
        nav(SL);
        repeat (2) @(posedge clock);
        #1;
        chk("hold_sel", 32'(choiceValid), 0);
        menuActive = 1'b0;
        @(posedge clock); #1;
        chk("exit_sel", 32'(selIdx), 0);
        menuActive = 1'b1;
        @(posedge clock); #1;
        mv(DN, 1, "menu_back");
        menuActive = 1'b0;
        nav(DN);
        fs();
        menuActive = 1'b1;
        fs();
        chk("inactive", 32'(selIdx), 1);

        pix2("blk0", 130, 224, 7);
        frame2();
        pix2("blk1", 130, 224, 7);
        frame2();
        pix2("blk2", 130, 224, 3);
        frame2();
        pix2("blk3", 130, 224, 3);
        frame2();
        pix2("blk4", 130, 224, 7);

        // Reset asserted mid-cycle, away from any rising edge.
        curAddress = 19'(40 * 640 + 204);
        repeat (2) @(posedge clock);
        #3;
        resetn = 1'b0;
        #1;
        chk("ar_addr", 32'(addrToRead), 1923);
        chk("ar_idx", 32'(indexOut), 0);
        chk("ar_col", 32'(colorOut), 0);
        chk("ar_sel", 32'(selIdx), 0);
        chk("ar_ch", 32'(choice), 0);
        chk("ar_cv", 32'(choiceValid), 0);
        @(posedge clock); #1;
        resetn = 1'b1;
        @(posedge clock); #1;
        chk("post_addr", 32'(addrToRead), 25940);
        @(posedge clock); #1;
        chk("post_idx", 32'(indexOut), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
